// File: rtl/pixel_sequencer.sv
// pixel_sequencer
//   Frame controller for the 4-bus pixel array. Walks the array through
//   erase -> expose -> convert -> read1 -> read2 once per frame with
//   programmable phase lengths, captures the two readout phases from the
//   pixData buses and hands them downstream as 16-bit words over valid/ready.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   start                single-cycle frame request (honoured in IDLE only)
//   continuous           auto-restart after each frame (sampled at READ2 exit)
//   expose_cycles        exposure length, latched at frame start (0 acts as 1)
//   erase..read2         one-hot registered array strobes
//   pixData1..pixData4   pixel buses, observed during the read phases
//   out_data/out_last    captured word / second-word-of-frame marker
//   out_valid/out_ready  downstream handshake
//   busy                 high in every state except IDLE
//   frame_done           one-cycle pulse at frame completion
//   frame_cnt            completed frame count (wraps)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start
// ERASE   | erase held for ERASE_CYCLES
// EXPOSE  | expose held for the latched exposure count
// CONVERT | convert held for CONVERT_CYCLES (ramp length)
// READ1   | read1 held, capture {pixData2,pixData1} once settled and slot free
// READ2   | read2 held, capture {pixData4,pixData3}, then finish the frame
module pixel_sequencer #(
    parameter int unsigned ERASE_CYCLES   = 5,
    parameter int unsigned CONVERT_CYCLES = 255,
    parameter int unsigned READ_SETTLE    = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic [CNT_W-1:0] expose_cycles,
    output logic             erase,
    output logic             expose,
    output logic             convert,
    output logic             read1,
    output logic             read2,
    input  logic [7:0]       pixData1,
    input  logic [7:0]       pixData2,
    input  logic [7:0]       pixData3,
    input  logic [7:0]       pixData4,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ1   = 3'd4,
        S_READ2   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] ERASE_LAST   = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONVERT_LAST = CNT_W'(CONVERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(READ_SETTLE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] exp_last_q, exp_last_d;
    logic [4:0]       strobe_q, strobe_d;
    logic [15:0]      data_q, data_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic             slot_free;
    logic [CNT_W-1:0] exp_load;

    // The exposure terminal count is stored as (count-1) so a zero request
    // collapses onto the one-cycle case without a second compare.
    assign exp_load  = (expose_cycles == '0) ? '0 : expose_cycles - CNT_W'(1);
    assign slot_free = ~valid_q | out_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        exp_last_d = exp_last_q;
        data_d     = data_q;
        last_d     = last_q;
        valid_d    = valid_q & ~out_ready;
        done_d     = 1'b0;
        fcnt_d     = fcnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    exp_last_d = exp_load;
                    state_d    = S_ERASE;
                end
            end
            S_ERASE: begin
                if (cnt_q == ERASE_LAST) begin
                    state_d = S_EXPOSE;
                    cnt_d   = '0;
                end
            end
            S_EXPOSE: begin
                if (cnt_q == exp_last_q) begin
                    state_d = S_CONVERT;
                    cnt_d   = '0;
                end
            end
            S_CONVERT: begin
                if (cnt_q == CONVERT_LAST) begin
                    state_d = S_READ1;
                    cnt_d   = '0;
                end
            end
            S_READ1: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = cnt_q;
                    if (slot_free) begin
                        data_d  = {pixData2, pixData1};
                        last_d  = 1'b0;
                        valid_d = 1'b1;
                        state_d = S_READ2;
                        cnt_d   = '0;
                    end
                end
            end
            S_READ2: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = cnt_q;
                    if (slot_free) begin
                        data_d  = {pixData4, pixData3};
                        last_d  = 1'b1;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        fcnt_d  = fcnt_q + 8'd1;
                        cnt_d   = '0;
                        if (continuous) begin
                            exp_last_d = exp_load;
                            state_d    = S_ERASE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes come straight from flops so the array never sees decode glitches.
    always_comb begin
        strobe_d = '0;
        case (state_d)
            S_ERASE:   strobe_d[0] = 1'b1;
            S_EXPOSE:  strobe_d[1] = 1'b1;
            S_CONVERT: strobe_d[2] = 1'b1;
            S_READ1:   strobe_d[3] = 1'b1;
            S_READ2:   strobe_d[4] = 1'b1;
            default:   strobe_d    = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            exp_last_q <= '0;
            strobe_q   <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exp_last_q <= exp_last_d;
            strobe_q   <= strobe_d;
            data_q     <= data_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign erase      = strobe_q[0];
    assign expose     = strobe_q[1];
    assign convert    = strobe_q[2];
    assign read1      = strobe_q[3];
    assign read2      = strobe_q[4];
    assign out_data   = data_q;
    assign out_last   = last_q;
    assign out_valid  = valid_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_pixel_sequencer.sv
module tb_pixel_sequencer;

    localparam int ERASE_N   = 5;
    localparam int CONVERT_N = 255;
    localparam int SETTLE_N  = 2;
    localparam int LIMIT     = 2000;
    localparam int NV        = 4;

    typedef struct {
        logic [15:0] expose;
        logic [7:0]  p1, p2, p3, p4;
        int          n_exp;
        logic [15:0] w0, w1;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start, continuous, out_ready;
    logic [15:0] expose_cycles;
    logic [7:0]  pixData1, pixData2, pixData3, pixData4;
    logic        erase, expose, convert, read1, read2;
    logic [15:0] out_data;
    logic        out_last, out_valid, busy, frame_done;
    logic [7:0]  frame_cnt;

    logic        m_start, m_cont, m_ready;
    logic [15:0] m_expose_cycles;
    logic        m_erase, m_expose, m_convert, m_read1, m_read2;
    logic [15:0] m_out_data;
    logic        m_out_last, m_out_valid, m_busy, m_frame_done;
    logic [7:0]  m_frame_cnt;

    int total = 0;
    int bad   = 0;
    int exp_fcnt = 0;
    vec_t vecs[NV];

    pixel_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .expose_cycles(expose_cycles),
        .erase(erase), .expose(expose), .convert(convert), .read1(read1), .read2(read2),
        .pixData1(pixData1), .pixData2(pixData2), .pixData3(pixData3), .pixData4(pixData4),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    // Minimum-length phases: exercises 1-cycle ERASE/settle and the 8-bit wrap quickly.
    pixel_sequencer #(.ERASE_CYCLES(1), .CONVERT_CYCLES(1), .READ_SETTLE(1), .CNT_W(16)) u_min (
        .clk(clk), .reset(reset), .start(m_start), .continuous(m_cont),
        .expose_cycles(m_expose_cycles),
        .erase(m_erase), .expose(m_expose), .convert(m_convert), .read1(m_read1), .read2(m_read2),
        .pixData1(pixData1), .pixData2(pixData2), .pixData3(pixData3), .pixData4(pixData4),
        .out_data(m_out_data), .out_last(m_out_last), .out_valid(m_out_valid), .out_ready(m_ready),
        .busy(m_busy), .frame_done(m_frame_done), .frame_cnt(m_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int n, n_er, n_ex, n_cv, n_r1, n_r2, nw, oh_bad;
        logic [15:0] w0, w1;
        logic l0, l1;
        bit done;
        n = 0; n_er = 0; n_ex = 0; n_cv = 0; n_r1 = 0; n_r2 = 0; nw = 0; oh_bad = 0;
        w0 = 16'hxxxx; w1 = 16'hxxxx; l0 = 1'bx; l1 = 1'bx; done = 0;
        expose_cycles = v.expose;
        pixData1 = v.p1; pixData2 = v.p2; pixData3 = v.p3; pixData4 = v.p4;
        start = 1'b1;
        while (!done && n < LIMIT) begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
            n_er += int'(erase); n_ex += int'(expose); n_cv += int'(convert);
            n_r1 += int'(read1); n_r2 += int'(read2);
            if ($countones({erase, expose, convert, read1, read2}) > 1) oh_bad++;
            if (out_valid) begin
                if (nw == 0) begin w0 = out_data; l0 = out_last; end
                if (nw == 1) begin w1 = out_data; l1 = out_last; end
                nw++;
            end
            if (frame_done) done = 1;
        end
        chk($sformatf("v%0d frame_done seen", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d erase cycles", idx), n_er, ERASE_N);
        chk($sformatf("v%0d expose cycles", idx), n_ex, v.n_exp);
        chk($sformatf("v%0d convert cycles", idx), n_cv, CONVERT_N);
        chk($sformatf("v%0d read1 cycles", idx), n_r1, SETTLE_N);
        chk($sformatf("v%0d read2 cycles", idx), n_r2, SETTLE_N);
        chk($sformatf("v%0d latency", idx), n - 1, ERASE_N + v.n_exp + CONVERT_N + 2 * SETTLE_N);
        chk($sformatf("v%0d one-hot", idx), oh_bad, 0);
        chk($sformatf("v%0d word count", idx), nw, 2);
        chk($sformatf("v%0d word0", idx), 32'(w0), 32'(v.w0));
        chk($sformatf("v%0d last0", idx), 32'(l0), 32'd0);
        chk($sformatf("v%0d word1", idx), 32'(w1), 32'(v.w1));
        chk($sformatf("v%0d last1", idx), 32'(l1), 32'd1);
        exp_fcnt = (exp_fcnt + 1) % 256;
        chk($sformatf("v%0d frame_cnt", idx), 32'(frame_cnt), exp_fcnt);
        tick();
        chk($sformatf("v%0d valid after", idx), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d done pulse width", idx), 32'(frame_done), 32'd0);
        chk($sformatf("v%0d busy after", idx), 32'(busy), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int n, nfd, gap_bad, stall_bad, idle_bad, run, maxrun, mbad;
        bit got, last_ok;
        logic [7:0] fc255, fc256;

        vecs[0] = '{16'd10, 8'h11, 8'h22, 8'h33, 8'h44, 10, 16'h2211, 16'h4433};
        vecs[1] = '{16'd0,  8'ha5, 8'h5a, 8'h00, 8'hff, 1,  16'h5aa5, 16'hff00};
        vecs[2] = '{16'd1,  8'h01, 8'h80, 8'hfe, 8'h7f, 1,  16'h8001, 16'h7ffe};
        vecs[3] = '{16'd3,  8'hde, 8'had, 8'hbe, 8'hef, 3,  16'hadde, 16'hefbe};

        reset = 1'b0; start = 1'b0; continuous = 1'b0; out_ready = 1'b1;
        expose_cycles = '0;
        pixData1 = '0; pixData2 = '0; pixData3 = '0; pixData4 = '0;
        m_start = 1'b0; m_cont = 1'b0; m_ready = 1'b1; m_expose_cycles = '0;
        tick(); tick();
        chk("rst strobes", 32'({erase, expose, convert, read1, read2}), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_last", 32'(out_last), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        chk("idle without start", 32'(busy), 32'd0);

        for (int i = 0; i < NV; i++) run_frame(vecs[i], i);

        // Backpressure: hold out_ready low after the first word.
        expose_cycles = 16'd2;
        pixData1 = 8'h11; pixData2 = 8'h22; pixData3 = 8'h33; pixData4 = 8'h44;
        start = 1'b1; n = 0; got = 0;
        while (!got && n < LIMIT) begin
            tick(); n++;
            if (n == 1) start = 1'b0;
            if (out_valid) got = 1;
        end
        chk("bp first word seen", 32'(got), 32'd1);
        chk("bp first word data", 32'(out_data), 32'h2211);
        out_ready = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(read2 && out_valid && out_data == 16'h2211 && !out_last && !frame_done)) stall_bad++;
        end
        chk("bp stall stable", stall_bad, 0);
        out_ready = 1'b1;
        tick();
        chk("bp second word", 32'(out_data), 32'h4433);
        chk("bp second last", 32'(out_last), 32'd1);
        chk("bp valid kept", 32'(out_valid), 32'd1);
        chk("bp frame_done", 32'(frame_done), 32'd1);
        exp_fcnt = (exp_fcnt + 1) % 256;
        chk("bp frame_cnt", 32'(frame_cnt), exp_fcnt);
        tick();
        chk("bp valid cleared", 32'(out_valid), 32'd0);
        chk("bp busy low", 32'(busy), 32'd0);

        // start pulsed during EXPOSE is ignored.
        expose_cycles = 16'd20;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!expose && n < 100) begin tick(); n++; end
        chk("ign reached expose", 32'(expose), 32'd1);
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!frame_done && n < LIMIT) begin tick(); n++; end
        chk("ign frame_done", 32'(frame_done), 32'd1);
        exp_fcnt = (exp_fcnt + 1) % 256;
        chk("ign frame_cnt", 32'(frame_cnt), exp_fcnt);
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || frame_done) idle_bad++;
        end
        chk("ign no second frame", idle_bad, 0);

        // Continuous: clear during frame 3, expect exactly 3 frames back to back.
        expose_cycles = 16'd0; continuous = 1'b1; start = 1'b1;
        nfd = 0; gap_bad = 0; last_ok = 0;
        for (int c = 0; c < 1100; c++) begin
            tick();
            if (c == 0) start = 1'b0;
            if (frame_done) begin
                nfd++;
                if (nfd < 3 && !erase) gap_bad++;
                if (nfd == 3) last_ok = !erase && !busy;
                if (nfd == 2) continuous = 1'b0;
            end
        end
        chk("cont frame count", nfd, 3);
        chk("cont no idle gap", gap_bad, 0);
        chk("cont ends idle", 32'(last_ok), 32'd1);
        exp_fcnt = (exp_fcnt + 3) % 256;
        chk("cont frame_cnt", 32'(frame_cnt), exp_fcnt);

        // Asynchronous reset during CONVERT.
        expose_cycles = 16'd5;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!convert && n < 100) begin tick(); n++; end
        chk("rc reached convert", 32'(convert), 32'd1);
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        chk("rc strobes", 32'({erase, expose, convert, read1, read2}), 32'd0);
        chk("rc out_valid", 32'(out_valid), 32'd0);
        chk("rc busy", 32'(busy), 32'd0);
        chk("rc frame_cnt", 32'(frame_cnt), 32'd0);
        exp_fcnt = 0;
        @(posedge clk); #1 reset = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy || frame_done || out_valid) idle_bad++;
        end
        chk("rc stays idle", idle_bad, 0);
        run_frame(vecs[0], 9);

        // Minimum-phase instance: 1-cycle erase and frame_cnt wrap.
        pixData1 = 8'h11; pixData2 = 8'h22; pixData3 = 8'h33; pixData4 = 8'h44;
        m_cont = 1'b1; m_start = 1'b1;
        nfd = 0; run = 0; maxrun = 0; mbad = 0; fc255 = 8'h00; fc256 = 8'haa;
        for (int c = 0; c < 2000 && nfd < 256; c++) begin
            tick();
            if (c == 0) m_start = 1'b0;
            if (m_erase) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if ($countones({m_erase, m_expose, m_convert, m_read1, m_read2}) > 1) mbad++;
            if (m_frame_done) begin
                nfd++;
                if (nfd == 255) fc255 = m_frame_cnt;
                if (nfd == 256) fc256 = m_frame_cnt;
                if (!(m_out_valid && m_out_last && m_out_data == 16'h4433)) mbad++;
            end
        end
        chk("min frames", nfd, 256);
        chk("min erase one cycle", maxrun, 1);
        chk("min frame_cnt 255", 32'(fc255), 32'd255);
        chk("min frame_cnt wrap", 32'(fc256), 32'd0);
        chk("min one-hot/words", mbad, 0);
        m_cont = 1'b0;
        repeat (20) tick();
        chk("min idle after", 32'(m_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
